// File: rtl/ifc_logic_reduce_pkg.sv
// rtl/ifc_logic_reduce_pkg.sv - shared types and reduction helper for ifc_logic_reduce
package ifc_logic_reduce_pkg;

  localparam int RES_CNT_W = 16;
  localparam int MAX_N     = 8;
  localparam int MAX_W     = 32;

  typedef enum logic [1:0] {
    MODE_OR  = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2,
    MODE_NOR = 2'd3
  } mode_t;

  // Channels at index >= n are ignored, so unused array entries never affect AND
  function automatic logic [MAX_W-1:0] reduce(
    input logic [MAX_N-1:0][MAX_W-1:0] ops,
    input int                          n,
    input mode_t                       mode
  );
    logic [MAX_W-1:0] acc;
    acc = ops[0];
    for (int i = 1; i < MAX_N; i++) begin
      if (i < n) begin
        case (mode)
          MODE_AND: acc = acc & ops[i];
          MODE_XOR: acc = acc ^ ops[i];
          default:  acc = acc | ops[i];
        endcase
      end
    end
    if (mode == MODE_NOR) acc = ~acc;
    return acc;
  endfunction

endpackage

// File: rtl/ifc_logic_reduce_if.sv
// rtl/ifc_logic_reduce_if.sv - method-style handshake bundle for ifc_logic_reduce
interface ifc_logic_reduce_if
  import ifc_logic_reduce_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W    = 1
);
  logic [N_IN-1:0]      in_en;
  logic [N_IN*W-1:0]    in_data;
  logic [N_IN-1:0]      in_rdy;
  logic                 y_en;
  logic [W-1:0]         y_data;
  logic                 y_rdy;
  logic                 mode_en;
  logic [1:0]           mode_data;
  logic                 mode_rdy;
  logic [RES_CNT_W-1:0] res_count;

  modport master (
    output in_en, in_data, y_en, mode_en, mode_data,
    input  in_rdy, y_data, y_rdy, mode_rdy, res_count
  );

  modport slave (
    input  in_en, in_data, y_en, mode_en, mode_data,
    output in_rdy, y_data, y_rdy, mode_rdy, res_count
  );
endinterface

// File: rtl/ifc_res_fifo.sv
// rtl/ifc_res_fifo.sv - synchronous result FIFO with MSB-wrap pointers
module ifc_res_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  // Head is forced to zero when empty so the output is defined out of reset
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ifc_logic_reduce.sv
// rtl/ifc_logic_reduce.sv - N-channel W-bit logic reduction with method handshakes
module ifc_logic_reduce
  import ifc_logic_reduce_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  ifc_logic_reduce_if.slave bus
);
  logic [N_IN-1:0]           valid;
  logic [N_IN-1:0][W-1:0]    opnd;
  mode_t                     mode;
  logic [RES_CNT_W-1:0]      res_count;
  logic [N_IN-1:0]           in_fire;
  logic                      compute;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [MAX_N-1:0][MAX_W-1:0] ops_ext;
  logic [MAX_W-1:0]          red_full;
  logic [W-1:0]              result;
  logic                      unused_red;

  assign in_fire = bus.in_en & ~valid;
  assign compute = (&valid) && !fifo_full;
  assign pop     = bus.y_en && !fifo_empty;

  always_comb begin
    ops_ext = '0;
    for (int i = 0; i < N_IN; i++) ops_ext[i][W-1:0] = opnd[i];
  end

  assign red_full   = reduce(ops_ext, N_IN, mode);
  assign result     = red_full[W-1:0];
  assign unused_red = ^red_full;

  assign bus.in_rdy    = ~valid;
  assign bus.mode_rdy  = !(|valid) && !compute;
  assign bus.y_rdy     = !fifo_empty;
  assign bus.res_count = res_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid     <= '0;
      mode      <= MODE_OR;
      res_count <= '0;
    end else begin
      // Compute only fires with every slot full, so no put can race the clear
      if (compute) valid <= '0;
      else         valid <= valid | in_fire;
      if (bus.mode_en && bus.mode_rdy) mode <= mode_t'(bus.mode_data);
      if (pop) res_count <= res_count + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_IN; i++) begin
      if (in_fire[i]) opnd[i] <= bus.in_data[i*W +: W];
    end
  end

  ifc_res_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (compute),
    .push_data (result),
    .pop       (pop),
    .pop_data  (bus.y_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
